// File: rtl/mem_pkg.sv
// Shared memory-path definitions: memOp/memSize encodings, the CPU address
// map, the queued store entry layout and the lane formatter used by both the
// store path and the read-side formatter.
package mem_pkg;

  localparam logic [1:0] MEM_DISABLE   = 2'b00;
  localparam logic [1:0] MEM_READ_SEXT = 2'b01;
  localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
  localparam logic [1:0] MEM_WRITE     = 2'b11;

  localparam logic [1:0] BYTE     = 2'b00;
  localparam logic [1:0] HALFWORD = 2'b01;
  localparam logic [1:0] WORD     = 2'b10;

  localparam logic [31:0] CPU_BRAM_START = 32'h0000_0000;
  localparam logic [31:0] CPU_BRAM_END   = 32'h007F_FF00;
  localparam logic [31:0] DIN_REG        = 32'h0200_0000;
  localparam logic [31:0] DOUT_REG       = 32'h0200_0100;

  typedef enum logic {
    TGT_BRAM = 1'b0,
    TGT_DOUT = 1'b1
  } target_e;

  // One queued store: word-aligned address, lane enables, lane data, target.
  typedef struct packed {
    logic [31:0] word_addr;
    logic [3:0]  we;
    logic [31:0] data;
    target_e     target;
  } store_entry_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] data;
    logic        bad;
  } lane_fmt_t;

  // Byte offset k lives in lane bits [31-8k:24-8k], so lane 3 holds offset 0.
  // bad flags a misaligned access or an illegal size encoding.
  function automatic lane_fmt_t lane_format(input logic [1:0]  size,
                                            input logic [1:0]  off,
                                            input logic [31:0] v);
    lane_fmt_t r;
    r.we   = 4'b0000;
    r.data = 32'h0;
    r.bad  = 1'b0;
    case (size)
      BYTE: begin
        r.we   = 4'b1000 >> off;
        r.data = {4{v[7:0]}};
      end
      HALFWORD: begin
        r.data = {2{v[7:0], v[15:8]}};
        case (off)
          2'b00:   r.we = 4'b1100;
          2'b10:   r.we = 4'b0011;
          default: r.bad = 1'b1;
        endcase
      end
      WORD: begin
        r.data = {v[7:0], v[15:8], v[23:16], v[31:24]};
        if (off == 2'b00) r.we = 4'b1111;
        else              r.bad = 1'b1;
      end
      default: r.bad = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_store_unit_if.sv
// Store request / BRAM write port bundle for mem_store_unit.
// Handshake: a request transfers on a rising edge where reqValid && reqReady
// are both high; reqValid/addr/memOp/memSize/storeData must stay stable while
// reqValid is high and reqReady is low. memGrant is sampled each cycle and a
// BRAM write happens on every edge where bramEn is high.
interface mem_store_unit_if;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] addr;
  logic [1:0]  memOp;
  logic [1:0]  memSize;
  logic [31:0] storeData;
  logic        memGrant;
  logic        bramEn;
  logic [3:0]  bramWe;
  logic [31:0] bramAddr;
  logic [31:0] bramDin;
  logic [31:0] doutReg;
  logic        pending;
  logic        fault;
  logic [31:0] faultAddr;

  modport master (
    output reqValid, addr, memOp, memSize, storeData, memGrant,
    input  reqReady, bramEn, bramWe, bramAddr, bramDin, doutReg,
           pending, fault, faultAddr
  );

  modport slave (
    input  reqValid, addr, memOp, memSize, storeData, memGrant,
    output reqReady, bramEn, bramWe, bramAddr, bramDin, doutReg,
           pending, fault, faultAddr
  );
endinterface

// File: rtl/store_fifo2.sv
// Generic 2-deep FIFO with valid/ready on both sides and an occupancy count.
// in_ready depends only on the registered count (no same-cycle pop lookahead).
module store_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         push;
  logic         pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Occupancy update from push/pop.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count; reset discards any entries in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_store_unit.sv
// Store-side memory unit: formats CPU stores into lane layout, rejects
// misaligned or unmapped stores, and queues up to two stores for the shared
// BRAM write port or the locally owned DOUT register.
module mem_store_unit
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mem_store_unit_if.slave   bus
);

  localparam int EntryW = $bits(store_entry_t);

  lane_fmt_t    fmt;
  logic         in_bram;
  logic         is_dout;
  logic         bad;
  logic         accept;
  logic         push;
  logic         fifo_ready;
  store_entry_t new_entry;
  logic [EntryW-1:0] head_bits;
  store_entry_t head;
  logic         head_valid;
  logic         head_pop;
  logic [1:0]   count;
  logic         bram_en;
  logic         dout_wr;
  logic         fault_d;
  logic         fault_q;
  logic [31:0]  fault_addr_d;
  logic [31:0]  fault_addr_q;
  logic [31:0]  dout_d;
  logic [31:0]  dout_q;

  // Request decode: lane formatting, address map and accept/fault split.
  // CPU_BRAM_START is zero, so only the upper bound needs a compare.
  always_comb begin
    fmt       = lane_format(bus.memSize, bus.addr[1:0], bus.storeData);
    in_bram   = (bus.addr <= CPU_BRAM_END);
    is_dout   = (bus.addr == DOUT_REG);
    bad       = fmt.bad || (!in_bram && !is_dout);
    accept    = bus.reqValid && fifo_ready && (bus.memOp == MEM_WRITE);
    push      = accept && !bad;
    fault_d   = accept && bad;
    new_entry.word_addr = {bus.addr[31:2], 2'b00};
    new_entry.we        = fmt.we;
    new_entry.data      = fmt.data;
    new_entry.target    = is_dout ? TGT_DOUT : TGT_BRAM;
  end

  store_fifo2 #(.W(EntryW)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .in_valid  (push),
    .in_ready  (fifo_ready),
    .in_data   (new_entry),
    .out_valid (head_valid),
    .out_ready (head_pop),
    .out_data  (head_bits),
    .count     (count)
  );

  // Head drain: BRAM entries wait for the grant, DOUT entries retire at once.
  always_comb begin
    head     = store_entry_t'(head_bits);
    bram_en  = head_valid && (head.target == TGT_BRAM) && bus.memGrant;
    dout_wr  = head_valid && (head.target == TGT_DOUT);
    head_pop = bram_en || dout_wr;
  end

  // Next DOUT contents and fault address.
  always_comb begin
    dout_d = dout_q;
    for (int i = 0; i < 4; i++) begin
      if (dout_wr && head.we[i]) dout_d[8*i +: 8] = head.data[8*i +: 8];
    end
    fault_addr_d = fault_d ? bus.addr : fault_addr_q;
  end

  // DOUT register and fault reporting state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q       <= 32'h0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
    end else begin
      dout_q       <= dout_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign bus.reqReady  = fifo_ready;
  assign bus.bramEn    = bram_en;
  assign bus.bramWe    = bram_en ? head.we        : 4'b0000;
  assign bus.bramAddr  = bram_en ? head.word_addr : 32'h0;
  assign bus.bramDin   = bram_en ? head.data      : 32'h0;
  assign bus.doutReg   = dout_q;
  assign bus.pending   = (count != 2'd0);
  assign bus.fault     = fault_q;
  assign bus.faultAddr = fault_addr_q;

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit: inputs change 1 ns after the rising
// edge and outputs are sampled 1 ns later, well away from the next edge.
module tb_mem_store_unit;
  import mem_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mem_store_unit_if bus ();

  mem_store_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    bus.reqValid  = 1'b1;
    bus.memOp     = MEM_WRITE;
    bus.addr      = a;
    bus.memSize   = sz;
    bus.storeData = d;
    #1;
  endtask

  task automatic idle();
    bus.reqValid = 1'b0;
    bus.memOp    = MEM_DISABLE;
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_reqReady"},  bus.reqReady,  32'd1);
    chk({tag, "_bramEn"},    bus.bramEn,    32'd0);
    chk({tag, "_bramWe"},    bus.bramWe,    32'd0);
    chk({tag, "_bramAddr"},  bus.bramAddr,  32'd0);
    chk({tag, "_bramDin"},   bus.bramDin,   32'd0);
    chk({tag, "_doutReg"},   bus.doutReg,   32'd0);
    chk({tag, "_pending"},   bus.pending,   32'd0);
    chk({tag, "_fault"},     bus.fault,     32'd0);
    chk({tag, "_faultAddr"}, bus.faultAddr, 32'd0);
  endtask

  task automatic chk_write(input string tag, input logic [3:0] we,
                           input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_bramEn"},   bus.bramEn,   32'd1);
    chk({tag, "_bramWe"},   bus.bramWe,   {28'd0, we});
    chk({tag, "_bramAddr"}, bus.bramAddr, a);
    chk({tag, "_bramDin"},  bus.bramDin,  d);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    bus.reqValid  = 1'b0;
    bus.addr      = 32'h0;
    bus.memOp     = MEM_DISABLE;
    bus.memSize   = BYTE;
    bus.storeData = 32'h0;
    bus.memGrant  = 1'b1;

    // Reset state
    #2;
    chk_reset_vals("rst");
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Word store
    drive(32'h100, WORD, 32'h1122_3344);
    tick();
    idle();
    chk_write("word", 4'b1111, 32'h100, 32'h4433_2211);
    chk("word_pending", bus.pending, 32'd1);
    tick();
    chk("word_done_en", bus.bramEn, 32'd0);
    chk("word_done_we", bus.bramWe, 32'd0);
    chk("word_done_din", bus.bramDin, 32'd0);
    chk("word_done_pending", bus.pending, 32'd0);

    // Byte stores, back to back
    drive(32'h103, BYTE, 32'h0000_00AB);
    tick();
    drive(32'h100, BYTE, 32'h0000_00AB);
    chk_write("byte3", 4'b0001, 32'h100, 32'hABAB_ABAB);
    tick();
    idle();
    chk_write("byte0", 4'b1000, 32'h100, 32'hABAB_ABAB);
    tick();

    // Halfword aligned then misaligned
    drive(32'h102, HALFWORD, 32'h0000_BEEF);
    tick();
    drive(32'h101, HALFWORD, 32'h0000_BEEF);
    chk_write("half2", 4'b0011, 32'h100, 32'hEFBE_EFBE);
    chk("half2_fault", bus.fault, 32'd0);
    tick();
    idle();
    chk("half1_fault", bus.fault, 32'd1);
    chk("half1_faultAddr", bus.faultAddr, 32'h101);
    chk("half1_bramEn", bus.bramEn, 32'd0);
    chk("half1_pending", bus.pending, 32'd0);
    tick();
    chk("half1_fault_pulse", bus.fault, 32'd0);
    chk("half1_faultAddr_hold", bus.faultAddr, 32'h101);

    // Non-store memOp is ignored
    bus.reqValid = 1'b1;
    bus.memOp    = MEM_READ_ZEXT;
    bus.addr     = 32'h100;
    bus.memSize  = WORD;
    #1;
    tick();
    idle();
    chk("read_ignored_pending", bus.pending, 32'd0);
    chk("read_ignored_bramEn", bus.bramEn, 32'd0);
    chk("read_ignored_fault", bus.fault, 32'd0);

    // Illegal size and address-map edges
    drive(32'h200, 2'b11, 32'h1);
    tick();
    drive(32'h007F_FF00, BYTE, 32'h0000_0077);
    chk("size11_fault", bus.fault, 32'd1);
    chk("size11_faultAddr", bus.faultAddr, 32'h200);
    tick();
    drive(32'h007F_FF01, BYTE, 32'h0000_0077);
    chk_write("bram_end", 4'b1000, 32'h007F_FF00, 32'h7777_7777);
    tick();
    idle();
    chk("past_end_fault", bus.fault, 32'd1);
    chk("past_end_faultAddr", bus.faultAddr, 32'h007F_FF01);
    chk("past_end_bramEn", bus.bramEn, 32'd0);
    tick();

    // Backpressure: three stores with no grant
    bus.memGrant = 1'b0;
    drive(32'h200, WORD, 32'hA0A1_A2A3);
    chk("bp_ready0", bus.reqReady, 32'd1);
    tick();
    drive(32'h204, WORD, 32'hB0B1_B2B3);
    chk("bp_ready1", bus.reqReady, 32'd1);
    chk("bp_nogrant_en", bus.bramEn, 32'd0);
    tick();
    drive(32'h208, WORD, 32'hC0C1_C2C3);
    chk("bp_full_ready", bus.reqReady, 32'd0);
    chk("bp_full_pending", bus.pending, 32'd1);
    chk("bp_full_en", bus.bramEn, 32'd0);
    tick();
    chk("bp_still_full", bus.reqReady, 32'd0);
    bus.memGrant = 1'b1;
    #1;
    chk_write("bp_w0", 4'b1111, 32'h200, 32'hA3A2_A1A0);
    tick();
    chk("bp_ready_after_pop", bus.reqReady, 32'd1);
    chk_write("bp_w1", 4'b1111, 32'h204, 32'hB3B2_B1B0);
    tick();
    idle();
    chk_write("bp_w2", 4'b1111, 32'h208, 32'hC3C2_C1C0);
    tick();
    chk("bp_drained", bus.pending, 32'd0);
    chk("bp_drained_en", bus.bramEn, 32'd0);

    // DOUT register store ignores the grant
    bus.memGrant = 1'b0;
    drive(DOUT_REG, BYTE, 32'h0000_005A);
    tick();
    idle();
    chk("dout_pending", bus.pending, 32'd1);
    chk("dout_not_yet", bus.doutReg, 32'h0);
    chk("dout_bramEn", bus.bramEn, 32'd0);
    tick();
    chk("dout_value", bus.doutReg, 32'h5A00_0000);
    chk("dout_pending_clr", bus.pending, 32'd0);
    drive(DIN_REG, WORD, 32'hFFFF_FFFF);
    tick();
    idle();
    chk("din_fault", bus.fault, 32'd1);
    chk("din_faultAddr", bus.faultAddr, DIN_REG);
    tick();
    chk("din_dout_hold", bus.doutReg, 32'h5A00_0000);
    chk("din_pending", bus.pending, 32'd0);

    // Reset with two entries queued
    drive(32'h300, WORD, 32'h1234_5678);
    tick();
    drive(32'h304, WORD, 32'h9ABC_DEF0);
    tick();
    idle();
    chk("prerst_ready", bus.reqReady, 32'd0);
    reset = 1'b0;
    #1;
    chk_reset_vals("midrst");
    bus.memGrant = 1'b1;
    tick();
    chk_reset_vals("heldrst");
    reset = 1'b1;
    #1;
    tick();
    chk("postrst_bramEn", bus.bramEn, 32'd0);
    chk("postrst_pending", bus.pending, 32'd0);
    tick();
    chk("postrst_bramEn2", bus.bramEn, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
